// File: rtl/bnn_load_ctrl.sv
// bnn_load_ctrl
//   Streams nibble-wide configuration into the weight/threshold register file
//   of a small binary neural network (8-8-4 neurons by default). Each neuron
//   takes three nibbles: weight[3:0], weight[7:4], threshold. After the third
//   nibble the neuron is written with a one-cycle strobe. When the last neuron
//   has been written, a one-cycle done pulse is issued and cfg_valid becomes
//   sticky-high.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   start               : one-cycle load request, honoured only when idle
//   abort               : cancel an ongoing load (no effect when idle)
//   nib_valid, nib_data : upstream nibble stream
//   nib_ready           : nibble accepted on this cycle's rising edge if valid
//   wr_en, wr_addr,
//   wr_weight, wr_thresh: register-file write port, held between writes
//   busy, done          : load in progress / load finished pulse
//   cfg_valid           : every neuron holds a complete configuration
//   neuron_cnt          : index of the neuron currently being loaded
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// W_LO    | waiting for weight[3:0] nibble
// W_HI    | waiting for weight[7:4] nibble
// THR     | waiting for threshold nibble
// WRITE   | one-cycle write strobe for the current neuron
// DONE    | one-cycle done pulse after the last neuron
//
// All outputs are registers loaded from the next-state values, so each output
// is aligned with the state it belongs to and no input reaches an output
// combinationally.

module bnn_load_ctrl #(
    parameter int NUM_NEURONS = 20,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              nib_valid,
    input  logic [3:0]        nib_data,
    output logic              nib_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_weight,
    output logic [3:0]        wr_thresh,
    output logic              busy,
    output logic              done,
    output logic              cfg_valid,
    output logic [ADDR_W-1:0] neuron_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_LO  = 3'd1,
        W_HI  = 3'd2,
        THR   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        weight_q, weight_d;
    logic [3:0]        thresh_q, thresh_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_weight_q, wr_weight_d;
    logic [3:0]        wr_thresh_q, wr_thresh_d;
    logic              nib_ready_q, nib_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    // nib_ready_q is already decoded for the current state, so it doubles as
    // the "this state consumes a nibble" qualifier.
    assign accept = nib_valid && nib_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        weight_d    = weight_q;
        thresh_d    = thresh_q;
        cfg_valid_d = cfg_valid_q;

        if (abort && (state_q != IDLE)) begin
            // Any nibble handshaken this cycle is dropped along with the load.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d       = '0;
                        cfg_valid_d = 1'b0;
                        state_d     = W_LO;
                    end
                end
                W_LO: begin
                    if (accept) begin
                        weight_d[3:0] = nib_data;
                        state_d       = W_HI;
                    end
                end
                W_HI: begin
                    if (accept) begin
                        weight_d[7:4] = nib_data;
                        state_d       = THR;
                    end
                end
                THR: begin
                    if (accept) begin
                        thresh_d = nib_data;
                        state_d  = WRITE;
                    end
                end
                WRITE: begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = W_LO;
                    end
                end
                DONE: begin
                    // Set on leaving DONE so an abort during DONE keeps it clear.
                    cfg_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered outputs describe the state being entered.
        wr_en_d     = (state_d == WRITE);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        nib_ready_d = (state_d == W_LO) || (state_d == W_HI) || (state_d == THR);

        wr_addr_d   = wr_addr_q;
        wr_weight_d = wr_weight_q;
        wr_thresh_d = wr_thresh_q;
        if (state_d == WRITE) begin
            wr_addr_d   = cnt_d;
            wr_weight_d = weight_d;
            wr_thresh_d = thresh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            weight_q    <= '0;
            thresh_q    <= '0;
            cfg_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_weight_q <= '0;
            wr_thresh_q <= '0;
            nib_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            weight_q    <= weight_d;
            thresh_q    <= thresh_d;
            cfg_valid_q <= cfg_valid_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_weight_q <= wr_weight_d;
            wr_thresh_q <= wr_thresh_d;
            nib_ready_q <= nib_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign nib_ready  = nib_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_weight  = wr_weight_q;
    assign wr_thresh  = wr_thresh_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_valid  = cfg_valid_q;
    assign neuron_cnt = cnt_q;

endmodule
